// File: rtl/dsp_mac_ctrl.sv
// Dot-product sequencer for a DSP48A1-style slice: streams signed A/B pairs into
// the multiplier, steers OPMODE to accumulate, and returns the final P per vector.
module dsp_mac_ctrl #(
    parameter int PIPE_LAT = 3,
    parameter int LEN_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    input  logic             s_last,
    input  logic             cfg_bias_en,
    input  logic [47:0]      cfg_bias,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [47:0]      m_data,
    output logic [LEN_W-1:0] m_count,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p
);
    localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    localparam logic [7:0] OP_IDLE       = 8'h00;
    localparam logic [7:0] OP_FIRST      = 8'h01;
    localparam logic [7:0] OP_FIRST_BIAS = 8'h0D;
    localparam logic [7:0] OP_ACC        = 8'h09;
    localparam logic [7:0] OP_HOLD       = 8'h08;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       op_stage;
    logic [LEN_W-1:0] beat_cnt;
    logic [DW-1:0]    drain_cnt;
    logic             accept;

    assign accept = s_valid && s_ready;
    assign dsp_c  = cfg_bias;
    assign dsp_ce = ~RST;

    // op_stage delays each beat's OPMODE by one extra cycle so it meets the
    // product at the slice's M stage rather than at the A1/B1 registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_count    <= '0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= OP_IDLE;
            op_stage   <= OP_IDLE;
            beat_cnt   <= '0;
            drain_cnt  <= '0;
        end else begin
            dsp_opmode <= op_stage;

            if (accept) begin
                dsp_a <= s_a;
                dsp_b <= s_b;
            end

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    op_stage <= OP_IDLE;
                    s_ready  <= 1'b1;
                    if (accept) begin
                        op_stage <= cfg_bias_en ? OP_FIRST_BIAS : OP_FIRST;
                        beat_cnt <= LEN_W'(1);
                        if (s_last) begin
                            state     <= DRAIN;
                            s_ready   <= 1'b0;
                            drain_cnt <= DW'(PIPE_LAT);
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    op_stage <= OP_HOLD;
                    s_ready  <= 1'b1;
                    if (accept) begin
                        op_stage <= OP_ACC;
                        if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                        if (s_last) begin
                            state     <= DRAIN;
                            s_ready   <= 1'b0;
                            drain_cnt <= DW'(PIPE_LAT);
                        end
                    end
                end

                // P is frozen under HOLD, so an unread previous result can stall us here safely.
                DRAIN: begin
                    op_stage <= OP_HOLD;
                    s_ready  <= 1'b0;
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end else if (!m_valid || m_ready) begin
                        m_data  <= dsp_p;
                        m_count <= beat_cnt;
                        m_valid <= 1'b1;
                        state   <= IDLE;
                        s_ready <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    op_stage <= OP_IDLE;
                    s_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
